// File: rtl/hazard_detect_unit.sv
// Hazard detection for the non-forwarding five-stage pipeline.
// Shadow scoreboard of in-flight rd plus saturating stall/flush counters.
module hazard_detect_unit #(
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic             id_rs1_used_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       id_rd_addr_i,
  input  logic             id_rd_wren_i,
  input  logic             ex_br_taken_i,
  output logic [1:0]       hazard_op_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } sb_ent_t;

  localparam logic [1:0] HZ_NONE = 2'd0;
  localparam logic [1:0] HZ_DATA = 2'd1;
  localparam logic [1:0] HZ_CTRL = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  sb_ent_t sb_ex;
  sb_ent_t sb_mem;
  sb_ent_t sb_wb;
  sb_ent_t id_ent;

  logic rs1_hit;
  logic rs2_hit;
  logic data_hit;

  function automatic logic src_hit(
    input logic       used,
    input logic [4:0] addr,
    input sb_ent_t    ent
  );
    return used && (addr != 5'd0)
      && ent.v && (ent.rd == addr);
  endfunction

  // A source hits if any compared scoreboard entry holds it.
  always_comb begin
    rs1_hit = src_hit(id_rs1_used_i, id_rs1_addr_i, sb_ex)
      || src_hit(id_rs1_used_i, id_rs1_addr_i, sb_mem)
      || ((WB_BYPASS == 0)
        && src_hit(id_rs1_used_i, id_rs1_addr_i, sb_wb));
    rs2_hit = src_hit(id_rs2_used_i, id_rs2_addr_i, sb_ex)
      || src_hit(id_rs2_used_i, id_rs2_addr_i, sb_mem)
      || ((WB_BYPASS == 0)
        && src_hit(id_rs2_used_i, id_rs2_addr_i, sb_wb));
    data_hit = id_valid_i && (rs1_hit || rs2_hit);
  end

  // Priority: reset, then control flush, then data stall.
  always_comb begin
    hazard_op_o = HZ_NONE;
    priority case (1'b1)
      rst_i:         hazard_op_o = HZ_NONE;
      ex_br_taken_i: hazard_op_o = HZ_CTRL;
      data_hit:      hazard_op_o = HZ_DATA;
      default:       hazard_op_o = HZ_NONE;
    endcase
  end

  // Entry the ID instruction would leave in ID/EX if it advances.
  always_comb begin
    id_ent.v  = id_valid_i && id_rd_wren_i
      && (id_rd_addr_i != 5'd0);
    id_ent.rd = id_rd_addr_i;
  end

  // Scoreboard shifts with the pipeline; stalls and flushes insert a bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      if (hazard_op_o == HZ_NONE) begin
        sb_ex <= id_ent;
      end else begin
        sb_ex <= '0;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if ((hazard_op_o == HZ_DATA) && (stall_cnt_o != CNT_MAX)) begin
        stall_cnt_o <= stall_cnt_o + CNT_ONE;
      end
      if ((hazard_op_o == HZ_CTRL) && (flush_cnt_o != CNT_MAX)) begin
        flush_cnt_o <= flush_cnt_o + CNT_ONE;
      end
    end
  end

endmodule

// File: doc/hazard_detect_unit.md
# hazard_detect_unit

Hazard detection for the non-forwarding five-stage pipeline. Sits in ID and drives the 2-bit hazard opcode consumed by the pipeline-register enable/reset controller:
- 0 = none.
- 1 = data stall: hold PC and IF/ID, bubble ID/EX.
- 2 = control flush: squash IF/ID and ID/EX.

Keeps an internal shadow scoreboard of destination registers in flight, so it needs no write-back feedback from the datapath. Also keeps saturating stall/flush performance counters.

## Interface
- WB_BYPASS, default 1: 1 = register file is write-through, so the MEM/WB destination is not compared; 0 = MEM/WB is compared as well.
- CNT_W, default 16: width of the performance counters.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- id_valid_i  in  1  ID holds a real instruction (0 = bubble).
- id_rs1_addr_i  in  5  source register 1 of the ID instruction.
- id_rs1_used_i  in  1  ID instruction reads rs1.
- id_rs2_addr_i  in  5  source register 2 of the ID instruction.
- id_rs2_used_i  in  1  ID instruction reads rs2.
- id_rd_addr_i  in  5  destination register of the ID instruction.
- id_rd_wren_i  in  1  ID instruction writes rd.
- ex_br_taken_i  in  1  branch or jump resolved taken in EX this cycle.
- hazard_op_o  out  2  0 none / 1 data / 2 control; 3 is never driven.
- stall_cnt_o  out  CNT_W  cycles with hazard_op_o==1, saturating.
- flush_cnt_o  out  CNT_W  cycles with hazard_op_o==2, saturating.

## Operation
- The scoreboard has three entries, each a valid bit plus a 5-bit rd: sb_ex (mirrors ID/EX), sb_mem (mirrors EX/MEM), sb_wb (mirrors MEM/WB).
- An entry's valid bit is set only for a real instruction (id_valid_i=1) that writes rd (id_rd_wren_i=1) with rd != 0.
- A source matches an entry when: its used bit is set, its address is nonzero, the entry is valid, and the addresses are equal.
- The sb_wb entry is compared only when WB_BYPASS=0.
- Register x0 never causes a hazard.
- The hazard opcode is chosen by priority:
  - ex_br_taken_i=1 gives 2. Control wins over data because the ID instruction is squashed.
  - Otherwise, id_valid_i=1 with any rs1/rs2 match gives 1.
  - Otherwise 0.
- Scoreboard update on each clock edge (no rst_i):
  - sb_wb <= sb_mem and sb_mem <= sb_ex, unconditionally.
  - If hazard_op_o==0, sb_ex <= {id_valid_i & id_rd_wren_i & (id_rd_addr_i!=0), id_rd_addr_i}.
  - If hazard_op_o is 1 or 2, sb_ex <= invalid, because a bubble enters ID/EX.
- Counters:
  - stall_cnt_o increments on cycles with hazard_op_o==1 and holds at all-ones.
  - flush_cnt_o increments on cycles with hazard_op_o==2 and holds at all-ones.
- On rst_i: all scoreboard entries become invalid, rd fields become 0, and both counters become 0.

## Timing
- hazard_op_o is combinational from the current inputs and registered scoreboard. Zero latency: it is used in the same cycle by the pipeline-register controller.
- While rst_i=1, hazard_op_o is forced to 0.
- After rst_i, hazard_op_o is 0 until a hazard occurs; both counters read 0.
- Dependent instruction directly behind its producer:
  - WB_BYPASS=1: 2 stall cycles (producer in ID/EX, then in EX/MEM).
  - WB_BYPASS=0: 3 stall cycles.
- One instruction between producer and consumer: 1 stall (WB_BYPASS=1) or 2 stalls (WB_BYPASS=0).
- Flush lasts exactly one cycle per ex_br_taken_i pulse.
- The cycle after a flush sees an invalid sb_ex, so a squashed instruction never causes a stall.
- Branch taken during a stall: that cycle is 2, and the stalled consumer is squashed.
- rs1 and rs2 both matching, or matching different entries: still a single 1 per cycle; the stall lasts until the youngest match leaves the compared window.
- rst_i asserted mid-stall: the next cycle shows hazard_op_o=0 and an empty scoreboard, even if the ID inputs are unchanged.
- Counters at all-ones stay all-ones on further stalls or flushes.

## Test plan
- Reset, then "addi x5" followed by "add x6,x5,x1", WB_BYPASS=1 -> hazard_op_o: 0, then 1, 1, then 0. stall_cnt_o=2.
- Same sequence with WB_BYPASS=0 -> three cycles of 1. Same sequence with rd=x0 -> no stall.
- Producer of x7 at cycle 0, stall in flight, ex_br_taken_i=1 at cycle 1 -> hazard_op_o=2 at cycle 1, then 0 (bubble behind the squash). flush_cnt_o=1.
- Writer of x3, an independent instruction, then a reader of x3 (rs2 only, rs1_used=0 with rs1=x3 wrong) -> exactly 1 stall with WB_BYPASS=1; rs1 mismatch ignored.
- Assert rst_i for one cycle in the middle of a 2-cycle stall -> hazard_op_o=0 during and after reset. Counters read 0 the cycle after.
- CNT_W=4, 20 consecutive stall cycles -> stall_cnt_o saturates at 15; flush_cnt_o stays 0.
